// File: rtl/msrv32_dmem_ahb_master_if.sv
// AHB-Lite bus bundle between the data-memory master and its slave.
interface msrv32_dmem_ahb_master_if;
    logic [31:0] haddr_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [1:0]  htrans_out;
    logic [31:0] hwdata_out;
    logic        hready_in;
    logic        hresp_in;
    logic [31:0] hrdata_in;

    modport master (
        output haddr_out, hwrite_out, hsize_out, htrans_out, hwdata_out,
        input  hready_in, hresp_in, hrdata_in
    );
    modport slave (
        input  haddr_out, hwrite_out, hsize_out, htrans_out, hwdata_out,
        output hready_in, hresp_in, hrdata_in
    );
endinterface

// File: rtl/msrv32_dmem_ahb_master.sv
// Data-memory AHB-Lite master: single NONSEQ transfers with wait-state and error handling.
// Define DMEM_WR_BUFFER_EN to add a one-entry posted write buffer.
module msrv32_dmem_ahb_master (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic [31:0] dmaddr_in,
    input  logic [31:0] dmdata_in,
    input  logic [3:0]  dmwr_mask_in,
    input  logic        dmwr_req_in,
    input  logic        dmrd_req_in,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        rdata_valid_out,
    output logic        bus_err_out,
    msrv32_dmem_ahb_master_if.master ahb
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d, rdata_valid_q, rdata_valid_d, bus_err_q, bus_err_d;

    // Address bits [1:0] come from the mask decode, never from the store unit.
    logic addr_lo_unused;
    assign addr_lo_unused = ^dmaddr_in[1:0];

    logic       dec_ok;
    logic [2:0] dec_size;
    logic [1:0] dec_off;
    always_comb begin
        dec_ok   = 1'b1;
        dec_size = 3'b000;
        dec_off  = 2'b00;
        case (dmwr_mask_in)
            4'b1111: dec_size = 3'b010;
            4'b0011: dec_size = 3'b001;
            4'b1100: begin dec_size = 3'b001; dec_off = 2'b10; end
            4'b0001: dec_off = 2'b00;
            4'b0010: dec_off = 2'b01;
            4'b0100: dec_off = 2'b10;
            4'b1000: dec_off = 2'b11;
            default: dec_ok = 1'b0;
        endcase
    end

    logic accept, wr_ok, wr_bad, rd_ok;
    assign accept = !stall_out && (dmwr_req_in || dmrd_req_in);
    assign wr_ok  = accept && dmwr_req_in && dec_ok;
    assign wr_bad = accept && dmwr_req_in && !dec_ok && (dmwr_mask_in != 4'b0000);
    assign rd_ok  = accept && !dmwr_req_in;

    logic        start, st_write;
    logic [31:0] st_addr, st_data;
    logic [2:0]  st_size;

`ifdef DMEM_WR_BUFFER_EN
    logic        buf_full_q, buf_full_d;
    logic [31:0] buf_addr_q, buf_addr_d, buf_data_q, buf_data_d;
    logic [2:0]  buf_size_q, buf_size_d;

    assign stall_out = buf_full_q || (dmrd_req_in && (state_q != S_IDLE || buf_full_q));

    always_comb begin
        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_size_d = buf_size_q;
        start      = 1'b0;
        st_write   = 1'b1;
        st_addr    = {dmaddr_in[31:2], dec_off};
        st_data    = dmdata_in;
        st_size    = dec_size;
        if (buf_full_q && state_q == S_IDLE) begin
            start      = 1'b1;
            st_addr    = buf_addr_q;
            st_data    = buf_data_q;
            st_size    = buf_size_q;
            buf_full_d = 1'b0;
        end else if (wr_ok) begin
            // An idle FSM with an empty buffer takes the write directly.
            if (state_q == S_IDLE) begin
                start = 1'b1;
            end else begin
                buf_full_d = 1'b1;
                buf_addr_d = {dmaddr_in[31:2], dec_off};
                buf_data_d = dmdata_in;
                buf_size_d = dec_size;
            end
        end else if (rd_ok) begin
            start    = 1'b1;
            st_write = 1'b0;
            st_addr  = {dmaddr_in[31:2], 2'b00};
            st_size  = 3'b010;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            buf_full_q <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_size_q <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_size_q <= buf_size_d;
        end
    end
`else
    assign stall_out = (state_q != S_IDLE);

    always_comb begin
        start    = wr_ok || rd_ok;
        st_write = wr_ok;
        st_addr  = wr_ok ? {dmaddr_in[31:2], dec_off} : {dmaddr_in[31:2], 2'b00};
        st_data  = dmdata_in;
        st_size  = wr_ok ? dec_size : 3'b010;
    end
`endif

    always_comb begin
        state_d       = state_q;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hwdata_d      = hwdata_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = wr_bad;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_ADDR;
                haddr_d  = st_addr;
                hwrite_d = st_write;
                hsize_d  = st_size;
                wdata_d  = st_data;
            end
            S_ADDR: if (ahb.hready_in) begin
                state_d = S_DATA;
                if (hwrite_q) hwdata_d = wdata_q;
            end
            S_DATA: begin
                // HRESP with HREADY in one cycle is a slave violation; close it as an error.
                if (ahb.hresp_in) begin
                    if (ahb.hready_in) begin
                        state_d   = S_IDLE;
                        bus_err_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (ahb.hready_in) begin
                    state_d = S_IDLE;
                    if (!hwrite_q) begin
                        rdata_d       = ahb.hrdata_in;
                        rdata_valid_d = 1'b1;
                    end
                end
            end
            S_ERR: if (ahb.hready_in) begin
                state_d   = S_IDLE;
                bus_err_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        htrans_d = (state_d == S_ADDR) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q       <= S_IDLE;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= '0;
            htrans_q      <= 2'b00;
            hwdata_q      <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            htrans_q      <= htrans_d;
            hwdata_q      <= hwdata_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign ahb.haddr_out   = haddr_q;
    assign ahb.hwrite_out  = hwrite_q;
    assign ahb.hsize_out   = hsize_q;
    assign ahb.htrans_out  = htrans_q;
    assign ahb.hwdata_out  = hwdata_q;
    assign rdata_out       = rdata_q;
    assign rdata_valid_out = rdata_valid_q;
    assign bus_err_out     = bus_err_q;
endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
// Scoreboard bench for the data-memory AHB master: driver pushes expectations, monitor pops on bus/response events.
module tb_msrv32_dmem_ahb_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dmaddr, dmdata;
    logic [3:0]  dmmask;
    logic        dmwr, dmrd;
    logic        stall, rvalid, berr;
    logic [31:0] rdata;

    msrv32_dmem_ahb_master_if bus();

    msrv32_dmem_ahb_master dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .dmaddr_in              (dmaddr),
        .dmdata_in              (dmdata),
        .dmwr_mask_in           (dmmask),
        .dmwr_req_in            (dmwr),
        .dmrd_req_in            (dmrd),
        .stall_out              (stall),
        .rdata_out              (rdata),
        .rdata_valid_out        (rvalid),
        .bus_err_out            (berr),
        .ahb                    (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [2:0] size; logic write; logic [31:0] data; } bus_t;
    typedef struct { bit err; logic [31:0] data; } resp_t;
    bus_t  bus_q[$];
    resp_t resp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: contiguous, naturally aligned lane groups of 1, 2 or 4 bytes.
    function automatic void decode(input logic [3:0] m, output bit legal, output logic [2:0] size,
                                   output logic [1:0] off);
        int pc, lo;
        pc = $countones(m);
        lo = 0;
        for (int i = 3; i >= 0; i--) if (m[i]) lo = i;
        legal = (pc == 4) || (pc == 1) || (pc == 2 && (lo == 0 || lo == 2) && m[lo+1]);
        size  = (pc == 4) ? 3'd2 : (pc == 2) ? 3'd1 : 3'd0;
        off   = 2'(lo);
    endfunction

    // Slave side: aw address-phase waits, dw data-phase waits, optional two-cycle ERROR.
    task automatic run_slave(input int aw, input int dw, input bit err, input logic [31:0] rd, output int ns);
        ns = 0;
        for (int i = 0; i < aw; i++) begin bus.hready_in = 1'b0; ns += int'(stall); tick(); end
        bus.hready_in = 1'b1; ns += int'(stall); tick();
        for (int i = 0; i < dw; i++) begin
            bus.hready_in = 1'b0; bus.hresp_in = 1'b0; ns += int'(stall); tick();
        end
        if (err) begin
            bus.hready_in = 1'b0; bus.hresp_in = 1'b1; ns += int'(stall); tick();
            bus.hready_in = 1'b1; bus.hresp_in = 1'b1; ns += int'(stall); tick();
        end else begin
            bus.hready_in = 1'b1; bus.hresp_in = 1'b0; bus.hrdata_in = rd; ns += int'(stall); tick();
        end
        bus.hready_in = 1'b1;
        bus.hresp_in  = 1'b0;
        bus.hrdata_in = $urandom;
    endtask

    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input int aw, input int dw, input bit err);
        bit legal, xfer, illegal, is_rd;
        logic [2:0] sz;
        logic [1:0] off;
        logic [31:0] rdat;
        int n, ns, exp_ns;
        n = 0;
        while (stall && n < 20) begin tick(); n++; end
        check(!stall, "stall_timeout", 32'(stall), 32'd0);
        decode(m, legal, sz, off);
        is_rd   = !wr && rd;
        xfer    = is_rd || (wr && legal);
        illegal = wr && !legal && (m != 4'b0000);
        rdat    = $urandom;
        if (xfer) begin
            if (wr) bus_q.push_back('{{a[31:2], off}, sz, 1'b1, d});
            else    bus_q.push_back('{{a[31:2], 2'b00}, 3'd2, 1'b0, 32'd0});
        end
        if (illegal || (xfer && err)) resp_q.push_back('{1'b1, 32'd0});
        else if (is_rd)               resp_q.push_back('{1'b0, rdat});
        dmwr = wr; dmrd = rd; dmaddr = a; dmdata = d; dmmask = m;
        tick();
        dmwr = 1'b0; dmrd = 1'b0; dmaddr = $urandom; dmdata = $urandom; dmmask = 4'($urandom);
        if (xfer) begin
            run_slave(aw, dw, err, rdat, ns);
            exp_ns = 2 + aw + dw + int'(err);
            check(ns == exp_ns && !stall, "stall_cycles", 32'(ns), 32'(exp_ns));
            check(rvalid == (is_rd && !err), "rvalid_at_end", 32'(rvalid), 32'(is_rd && !err));
            check(berr == err, "berr_at_end", 32'(berr), 32'(err));
            if (is_rd && !err) check(rdata == rdat, "rdata_at_end", rdata, rdat);
        end else begin
            check(berr == illegal && !rvalid && !stall, "no_xfer_resp", {30'd0, rvalid, berr},
                  {31'd0, illegal});
        end
        tick();
        check(!rvalid && !berr, "pulse_width", {30'd0, rvalid, berr}, 32'd0);
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check(bus.htrans_out == 2'b00 && bus.haddr_out == 0 && !bus.hwrite_out && bus.hsize_out == 0 &&
              bus.hwdata_out == 0, {tag, "_bus"}, bus.haddr_out, 32'd0);
        check(rdata == 0 && !rvalid && !berr && !stall, {tag, "_core"}, rdata, 32'd0);
    endtask

    // Monitor: pops the bus queue at each completed address phase, the response queue on each pulse.
    initial begin
        bit    pend;
        bus_t  cur;
        resp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin pend = 1'b0; continue; end
            if (pend) begin
                check(bus.htrans_out == 2'b00, "htrans_data_phase", 32'(bus.htrans_out), 32'd0);
                if (bus.hready_in) begin
                    if (cur.write) check(bus.hwdata_out == cur.data, "hwdata", bus.hwdata_out, cur.data);
                    pend = 1'b0;
                end
            end else if (bus.htrans_out == 2'b10 && bus.hready_in) begin
                if (bus_q.size() == 0) begin
                    check(1'b0, "unexpected_nonseq", bus.haddr_out, 32'd0);
                end else begin
                    cur = bus_q.pop_front();
                    check(bus.haddr_out == cur.addr, "haddr", bus.haddr_out, cur.addr);
                    check(bus.hsize_out == cur.size, "hsize", 32'(bus.hsize_out), 32'(cur.size));
                    check(bus.hwrite_out == cur.write, "hwrite", 32'(bus.hwrite_out), 32'(cur.write));
                    pend = 1'b1;
                end
            end
            if (rvalid || berr) begin
                if (resp_q.size() == 0) begin
                    check(1'b0, "unexpected_resp", {30'd0, rvalid, berr}, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    check(berr == e.err && rvalid == !e.err, "resp_kind", {30'd0, rvalid, berr}, 32'(e.err));
                    if (!e.err) check(rdata == e.data, "rdata", rdata, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] legal_m [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bit w, r;
        logic [3:0] m;
        rst_n = 1'b0; dmwr = 1'b0; dmrd = 1'b0; dmaddr = '0; dmdata = '0; dmmask = '0;
        bus.hready_in = 1'b1; bus.hresp_in = 1'b0; bus.hrdata_in = '0;
        tick(); tick();
        check_reset_values("reset_init");
        rst_n = 1'b1;
        tick();

        do_req(1, 0, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
        do_req(1, 0, 32'h200, 32'h00AB0000, 4'b0100, 0, 0, 0);
        do_req(0, 1, 32'h300, 32'h0, 4'b0000, 0, 2, 0);
        do_req(1, 0, 32'h400, 32'hCAFEF00D, 4'b0011, 0, 0, 1);
        do_req(1, 0, 32'h500, 32'h11111111, 4'b0101, 0, 0, 0);
        do_req(1, 0, 32'h600, 32'h22222222, 4'b0000, 0, 0, 0);
        do_req(1, 1, 32'h704, 32'h33333333, 4'b1100, 1, 1, 0);
        do_req(0, 1, 32'h80C, 32'h0, 4'b0000, 2, 0, 1);

        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            m = $urandom_range(0, 1) ? 4'($urandom) : legal_m[$urandom_range(0, 6)];
            do_req(w, r, $urandom, $urandom, m, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 5) == 0);
        end

        // Reset while the address phase is held by wait states.
        dmwr = 1'b1; dmaddr = 32'h900; dmdata = 32'h44444444; dmmask = 4'b1111;
        bus_q.push_back('{32'h900, 3'd2, 1'b1, 32'h44444444});
        tick();
        dmwr = 1'b0;
        bus.hready_in = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_values("reset_mid_addr");
        bus_q.delete();
        resp_q.delete();
        rst_n = 1'b1;
        bus.hready_in = 1'b1;
        tick(); tick();
        check_reset_values("reset_after");

        repeat (3) tick();
        check(bus_q.size() == 0, "bus_q_empty", 32'(bus_q.size()), 32'd0);
        check(resp_q.size() == 0, "resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
